// File: rtl/fp_sum_tree.sv
// Pipelined IEEE-754 single-precision summation tree: N_IN operands per beat, one beat per clock.
// The tree is built from fp_add_sub adders plus aligned pass-through delays, with a valid/tag pipeline alongside.

// Fixed-depth register delay; holds data only, so it is not reset.
module fp_dly #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe_d [DEPTH];
  logic [W-1:0] pipe_q [DEPTH];

  // NOTE: always_comb uses blocking '=' and gives every output a value on every pass; clocked blocks use '<='.
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // NOTE: data-only pipeline registers carry no reset; validity is tracked by a separate reset pipeline.
  always_ff @(posedge clk) pipe_q <= pipe_d;

  assign q = pipe_q[DEPTH-1];
endmodule

// Single-precision adder/subtractor (add_sub=1 adds), round-to-nearest-even, LAT clocks of latency.
module fp_add_sub #(
  parameter int LAT = 7
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        add_sub,
  output logic [31:0] y
);
  logic [31:0] bb, x, z, res;
  logic [8:0]  ex, ez, diff, e_n;
  logic [26:0] mx, mz, mz_sh, lost, n;
  logic [27:0] s;
  logic [4:0]  lz, sh;
  logic        a_nan, b_nan, a_inf, b_inf, up, ovf;
  logic [7:0]  ef;
  logic [30:0] mag_r;

  always_comb begin
    bb    = {b[31] ^ ~add_sub, b[30:0]};
    x     = a;
    z     = bb;
    if (a[30:0] < bb[30:0]) begin
      x = bb;
      z = a;
    end
    ex    = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
    ez    = (z[30:23] == 8'd0) ? 9'd1 : {1'b0, z[30:23]};
    mx    = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    mz    = {(z[30:23] != 8'd0), z[22:0], 3'b000};
    diff  = ex - ez;
    lost  = '0;
    mz_sh = '0;
    // Guard/round bits plus a sticky bit in the LSB keep rounding exact after alignment.
    if (diff >= 9'd27) begin
      mz_sh = {26'b0, |mz};
    end else begin
      mz_sh    = mz >> diff;
      lost     = mz << (9'd27 - diff);
      mz_sh[0] = mz_sh[0] | (|lost);
    end
    s = (x[31] ^ z[31]) ? ({1'b0, mx} - {1'b0, mz_sh}) : ({1'b0, mx} + {1'b0, mz_sh});

    lz = 5'd27;
    for (int i = 0; i <= 26; i++) if (s[i]) lz = 5'(26 - i);
    sh  = lz;
    n   = '0;
    e_n = '0;
    if (s[27]) begin
      n    = s[27:1];
      n[0] = s[1] | s[0];
      e_n  = ex + 9'd1;
    end else begin
      // Left-normalise, but never below the minimum exponent: the remainder stays subnormal.
      if ({4'b0, lz} > (ex - 9'd1)) sh = 5'(ex - 9'd1);
      n   = s[26:0] << sh;
      e_n = ex - {4'b0, sh};
    end
    ef    = n[26] ? e_n[7:0] : 8'd0;
    ovf   = (e_n >= 9'd255);
    up    = n[2] & (n[3] | n[1] | n[0]);
    // Rounding carry ripples from fraction into exponent, covering mantissa overflow and subnormal-to-normal.
    mag_r = {ef, n[25:3]} + 31'(up);

    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != bb[31]))) res = 32'h7FC0_0000;
    else if (a_inf)                                          res = a;
    else if (b_inf)                                          res = bb;
    else if (s == 28'd0)                                     res = {a[31] & bb[31], 31'd0};
    else if (ovf)                                            res = {x[31], 8'hFF, 23'd0};
    else                                                     res = {x[31], mag_r};
  end

  fp_dly #(.W(32), .DEPTH(LAT)) u_pipe (
    .clk (clk),
    .d   (res),
    .q   (y)
  );
endmodule

module fp_sum_tree #(
  parameter int N_IN    = 4,
  parameter int ADD_LAT = 7,
  parameter int TAG_W   = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iVALID,
  input  logic [N_IN*32-1:0]   iDATA,
  input  logic [N_IN-1:0]      iNEG,
  input  logic [TAG_W-1:0]     iTAG,
  output logic                 oVALID,
  output logic [31:0]          oSUM,
  output logic [TAG_W-1:0]     oTAG,
  output logic                 oBUSY
);
  localparam int LEVELS = (N_IN > 1) ? $clog2(N_IN) : 0;
  localparam int LAT    = 1 + LEVELS * ADD_LAT;
  localparam int CNT_W  = $clog2(LAT + 1);

  logic [31:0]      opnd_d [N_IN];
  logic [31:0]      opnd_q [N_IN];
  logic [31:0]      node   [LEVELS+1][N_IN];
  logic [TAG_W:0]   vt_d   [LAT];
  logic [TAG_W:0]   vt_q   [LAT];
  logic [CNT_W-1:0] busy_cnt_d, busy_cnt_q;
  logic             valid_out;

  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      opnd_d[k]     = iDATA[32*k +: 32];
      opnd_d[k][31] = iDATA[32*k+31] ^ iNEG[k];
    end
  end

  always_ff @(posedge iCLK) opnd_q <= opnd_d;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    assign node[0][k] = opnd_q[k];
  end

  // Level l holds ceil(N_IN/2^l) live elements; an odd last element rides a delay of adder depth.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int CNT = (N_IN + (1 << l) - 1) >> l;
    for (genvar j = 0; j < N_IN; j++) begin : g_node
      if (2*j + 1 < CNT) begin : g_add
        fp_add_sub #(.LAT(ADD_LAT)) u_add (
          .clk     (iCLK),
          .a       (node[l][2*j]),
          .b       (node[l][2*j+1]),
          .add_sub (1'b1),
          .y       (node[l+1][j])
        );
      end else if (2*j + 1 == CNT) begin : g_pass
        fp_dly #(.W(32), .DEPTH(ADD_LAT)) u_pass (
          .clk (iCLK),
          .d   (node[l][2*j]),
          .q   (node[l+1][j])
        );
      end else begin : g_tie
        assign node[l+1][j] = '0;
      end
    end
  end

  always_comb begin
    vt_d[0] = {iVALID, iTAG};
    for (int i = 1; i < LAT; i++) vt_d[i] = vt_q[i-1];
  end

  assign valid_out = vt_q[LAT-1][TAG_W];

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (iVALID && !valid_out)      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    else if (!iVALID && valid_out) busy_cnt_d = busy_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < LAT; i++) vt_q[i] <= '0;
      busy_cnt_q <= '0;
    end else begin
      vt_q       <= vt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign oVALID = valid_out;
  assign oSUM   = node[LEVELS][0];
  assign oTAG   = vt_q[LAT-1][TAG_W-1:0];
  assign oBUSY  = (busy_cnt_q != '0);
endmodule

// File: tb/tb_fp_sum_tree.sv
// Scoreboard bench for fp_sum_tree at N_IN=4, 3 and 1: the driver pushes expected sums from an exact
// fixed-point reference model, and a negedge monitor pops and checks sum, tag, latency and oBUSY.
module tb_fp_sum_tree;
  localparam int LAT4 = 15;
  localparam int LAT3 = 15;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         v4, v3, v1;
  logic [127:0] d4;
  logic [95:0]  d3;
  logic [31:0]  d1;
  logic [3:0]   n4;
  logic [2:0]   n3;
  logic         n1;
  logic [4:0]   t4;
  logic [3:0]   t3, t1;
  logic         ov4, ov3, ov1, ob4, ob3, ob1;
  logic [31:0]  os4, os3, os1;
  logic [4:0]   ot4;
  logic [3:0]   ot3, ot1;

  fp_sum_tree #(.N_IN(4), .ADD_LAT(7), .TAG_W(5)) u_dut4 (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(v4), .iDATA(d4), .iNEG(n4), .iTAG(t4),
    .oVALID(ov4), .oSUM(os4), .oTAG(ot4), .oBUSY(ob4));
  fp_sum_tree #(.N_IN(3), .ADD_LAT(7), .TAG_W(4)) u_dut3 (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(v3), .iDATA(d3), .iNEG(n3), .iTAG(t3),
    .oVALID(ov3), .oSUM(os3), .oTAG(ot3), .oBUSY(ob3));
  fp_sum_tree #(.N_IN(1), .ADD_LAT(7), .TAG_W(4)) u_dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(v1), .iDATA(d1), .iNEG(n1), .iTAG(t1),
    .oVALID(ov1), .oSUM(os1), .oTAG(ot1), .oBUSY(ob1));

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sbq [3][$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Every value in play is an integer multiple of 2^-30, so sums are exact in a longint.
  function automatic longint f2fix(input logic [31:0] f);
    longint mag;
    if (f[30:23] == 8'd0) return 0;
    mag = longint'({1'b1, f[22:0]}) <<< (int'(f[30:23]) - 120);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fix2f(input longint v);
    logic       s, up;
    longint     m, keep, rem, half;
    int         p, sh;
    if (v == 0) return 32'h0;
    s  = (v < 0);
    m  = s ? -v : v;
    p  = 0;
    up = 1'b0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    if (p <= 23) begin
      keep = m <<< (23 - p);
    end else begin
      sh   = p - 23;
      keep = m >>> sh;
      rem  = m & ((longint'(1) <<< sh) - 1);
      half = longint'(1) <<< (sh - 1);
      up   = (rem > half) || ((rem == half) && keep[0]);
    end
    return {s, 8'(p + 97), keep[22:0]} + 32'(up);
  endfunction

  // Pairwise tree order: adjacent pairs add with one rounding each, an odd last element passes through.
  function automatic logic [31:0] sum_model(input logic [31:0] ops [$]);
    logic [31:0] cur [$];
    logic [31:0] nxt [$];
    cur = ops;
    while (cur.size() > 1) begin
      nxt = {};
      for (int i = 0; i + 1 < cur.size(); i += 2) nxt.push_back(fix2f(f2fix(cur[i]) + f2fix(cur[i+1])));
      if (cur.size() % 2 == 1) nxt.push_back(cur[cur.size()-1]);
      cur = nxt;
    end
    return cur[0];
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
  endfunction

  function automatic logic [127:0] rnd_data();
    return {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
  endfunction

  task automatic issue(input int u, input logic [127:0] data, input logic [3:0] neg,
                       input logic [7:0] tag, input logic use_exp, input logic [31:0] exp_sum);
    logic [31:0] ops [$];
    exp_t        e;
    int          n;
    n = (u == 0) ? 4 : (u == 1) ? 3 : 1;
    for (int k = 0; k < n; k++) ops.push_back(data[32*k +: 32] ^ {neg[k], 31'd0});
    e.sum = use_exp ? exp_sum : sum_model(ops);
    e.tag = tag;
    e.cyc = cyc;
    sbq[u].push_back(e);
    case (u)
      0:       begin v4 = 1'b1; d4 = data;        n4 = neg;      t4 = tag[4:0]; end
      1:       begin v3 = 1'b1; d3 = data[95:0];  n3 = neg[2:0]; t3 = tag[3:0]; end
      default: begin v1 = 1'b1; d1 = data[31:0];  n1 = neg[0];   t1 = tag[3:0]; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    v4 = 1'b0;
    v3 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic mon_step(input int u, input logic v, input logic [31:0] s, input logic [7:0] t,
                          input logic busy, input int lat);
    exp_t e;
    logic exp_busy;
    exp_busy = (sbq[u].size() != 0) && (sbq[u][0].cyc < cyc);
    check($sformatf("u%0d busy cyc%0d", u, cyc), 32'(busy), 32'(exp_busy));
    if (v) begin
      if (sbq[u].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u%0d unexpected_valid cyc%0d: got oVALID=1 want 0 (nothing in flight)", u, cyc);
      end else begin
        e = sbq[u].pop_front();
        check($sformatf("u%0d sum tag%0d", u, e.tag), s, e.sum);
        check($sformatf("u%0d tag", u), 32'(t), 32'(e.tag));
        check($sformatf("u%0d latency tag%0d", u, e.tag), 32'(cyc - e.cyc), 32'(lat));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, ov4, os4, 8'(ot4), ob4, LAT4);
      mon_step(1, ov3, os3, 8'(ot3), ob3, LAT3);
      mon_step(2, ov1, os1, 8'(ot1), ob1, LAT1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] x, y, op;
    rst_n = 1'b1;
    v4 = 1'b0; v3 = 1'b0; v1 = 1'b0;
    d4 = '0;   d3 = '0;   d1 = '0;
    n4 = '0;   n3 = '0;   n1 = 1'b0;
    t4 = '0;   t3 = '0;   t1 = '0;
    #1 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) tick();
    check("reset oVALID4", 32'(ov4), 32'd0);
    check("reset oBUSY4",  32'(ob4), 32'd0);
    check("reset oTAG4",   32'(ot4), 32'd0);
    check("reset oVALID1", 32'(ov1), 32'd0);
    rst_n = 1'b1;

    // Directed: 1+2+3+4, then 1-2+3+4, odd-width tree, single operand negated back-to-back.
    issue(0, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 4'b0000, 8'd5, 1'b1, 32'h4120_0000);
    issue(1, {32'h0, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 4'b0000, 8'd3, 1'b1, 32'h40C0_0000);
    issue(2, {96'h0, 32'h3F80_0000}, 4'b0001, 8'd9, 1'b1, 32'hBF80_0000);
    tick();
    issue(0, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 4'b0010, 8'd6, 1'b1, 32'h40C0_0000);
    issue(2, {96'h0, 32'h4040_0000}, 4'b0000, 8'd10, 1'b1, 32'h4040_0000);
    tick();
    repeat (20) tick();

    // Streaming: operand k = i for 20 consecutive beats, sum 4*i.
    for (int i = 0; i < 20; i++) begin
      op = fix2f(longint'(i) <<< 30);
      issue(0, {op, op, op, op}, 4'b0000, 8'(i), 1'b1, fix2f(longint'(4 * i) <<< 30));
      tick();
    end
    repeat (20) tick();

    // Random beats with random gaps on all three trees, one exact-cancellation beat.
    for (int c = 0; c < 120; c++) begin
      if (c == 60) begin
        x = rnd_op();
        y = rnd_op();
        issue(0, {y, y, x, x}, 4'b0101, 8'd17, 1'b1, 32'h0000_0000);
      end else if ($urandom_range(3) != 0) begin
        issue(0, rnd_data(), 4'($urandom), 8'($urandom_range(31)), 1'b0, 32'h0);
      end
      if ($urandom_range(3) != 0) issue(1, rnd_data(), 4'($urandom), 8'($urandom_range(15)), 1'b0, 32'h0);
      if ($urandom_range(3) != 0) issue(2, rnd_data(), 4'($urandom), 8'($urandom_range(15)), 1'b0, 32'h0);
      tick();
    end
    for (int i = 0; i < 40 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; i++) tick();
    check("drain before reset", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);

    // Reset mid-flight: three beats dropped, the next one arrives exactly LAT clocks after acceptance.
    for (int i = 0; i < 3; i++) begin
      issue(0, rnd_data(), 4'($urandom), 8'(20 + i), 1'b0, 32'h0);
      tick();
    end
    repeat (2) tick();
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) sbq[u].delete();
    repeat (2) tick();
    rst_n = 1'b1;
    check("post-reset oBUSY4",  32'(ob4), 32'd0);
    check("post-reset oVALID4", 32'(ov4), 32'd0);
    check("post-reset oTAG4",   32'(ot4), 32'd0);
    issue(0, rnd_data(), 4'($urandom), 8'd29, 1'b0, 32'h0);
    tick();
    repeat (25) tick();

    for (int i = 0; i < 40 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; i++) tick();
    check("final drain u0", 32'(sbq[0].size()), 32'd0);
    check("final drain u1", 32'(sbq[1].size()), 32'd0);
    check("final drain u2", 32'(sbq[2].size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
